// File: rtl/abus_slave_pkg.sv
// Shared abus encodings: slave FSM state constants and the error read-data pattern.
package abus_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } abus_slv_state_e;

    localparam int ABUS_MAX_DW = 64;

    // Returned on a timed-out read; sliced down to the bus data width by each user.
    localparam logic [ABUS_MAX_DW-1:0] ABUS_ERR_DATA = '1;

    localparam int ABUS_WCNT_W = 8;

    function automatic logic [ABUS_WCNT_W-1:0] wait_sat_inc(input logic [ABUS_WCNT_W-1:0] cnt);
        return (cnt == {ABUS_WCNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/abus_addr_decode.sv
// Combinational window compare of a bus address against an aligned base; also used by
// the fabric's default-slave logic.
module abus_addr_decode
    import abus_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0100,
    parameter int                    LOCAL_AW   = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_window,
    output logic [LOCAL_AW-1:0]   offset
);

    localparam logic [ADDR_WIDTH-LOCAL_AW-1:0] BASE_HI = BASE_ADDR[ADDR_WIDTH-1:LOCAL_AW];

    always_comb begin
        in_window = (addr[ADDR_WIDTH-1:LOCAL_AW] == BASE_HI);
        offset    = addr[LOCAL_AW-1:0];
    end

endmodule

// File: rtl/abus_slave.sv
// abus responder: turns a decoded bus order into one register-file strobe, waits for
// reg_ready with timeout/abort, and holds the acknowledge until the master drops abus_req.
module abus_slave
    import abus_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0100,
    parameter int                    LOCAL_AW   = 8,
    parameter int                    WAIT_MAX   = 15
) (
    input  logic                  abus_clk,
    input  logic                  abus_rst,
    input  logic                  abus_req,
    input  logic                  abus_write,
    input  logic                  abus_read,
    input  logic                  abus_abort,
    input  logic [ADDR_WIDTH-1:0] abus_maddress,
    input  logic [DATA_WIDTH-1:0] abus_mwdata,
    output logic                  abus_ack,
    output logic [DATA_WIDTH-1:0] abus_srdata,
    output logic                  abus_sel,
    output logic                  abus_serr,
    output logic [LOCAL_AW-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ready
);

    localparam logic [ABUS_WCNT_W-1:0] WAIT_LIM = ABUS_WCNT_W'(WAIT_MAX);
    localparam logic [DATA_WIDTH-1:0]  ERR_DATA = ABUS_ERR_DATA[DATA_WIDTH-1:0];

    abus_slv_state_e         state_q, state_d;
    logic                    dir_wr_q, dir_wr_d;
    logic [LOCAL_AW-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    sel_q, sel_d;
    logic                    serr_q, serr_d;
    logic [DATA_WIDTH-1:0]   srdata_q, srdata_d;
    logic [ABUS_WCNT_W-1:0]  cnt_q, cnt_d;

    logic                    in_window;
    logic [LOCAL_AW-1:0]     offset;
    logic                    hit;

    abus_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .LOCAL_AW   (LOCAL_AW)
    ) u_decode (
        .addr      (abus_maddress),
        .in_window (in_window),
        .offset    (offset)
    );

    assign hit = abus_req & in_window;

    always_comb begin
        state_d  = state_q;
        dir_wr_d = dir_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        serr_d   = serr_q;
        srdata_d = srdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    if (abus_write ^ abus_read) begin
                        state_d  = S_ACCESS;
                        addr_d   = offset;
                        wdata_d  = abus_mwdata;
                        dir_wr_d = abus_write;
                        sel_d    = 1'b1;
                    end else if (abus_abort || (abus_write && abus_read)) begin
                        // Both orders at once is illegal and is answered like an abort.
                        state_d  = S_ACK;
                        sel_d    = 1'b1;
                        serr_d   = 1'b1;
                        srdata_d = '0;
                    end
                end
            end

            S_ACCESS: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (reg_ready) begin
                    state_d = S_ACK;
                    if (!dir_wr_q) begin
                        srdata_d = reg_rdata;
                    end
                end else if (abus_abort) begin
                    state_d = S_ACK;
                    serr_d  = 1'b1;
                end else if (cnt_q + 1'b1 == WAIT_LIM) begin
                    // Timeout fires on the WAIT_MAX-th cycle spent waiting.
                    state_d = S_ACK;
                    serr_d  = 1'b1;
                    cnt_d   = WAIT_LIM;
                    if (!dir_wr_q) begin
                        srdata_d = ERR_DATA;
                    end
                end else begin
                    cnt_d = wait_sat_inc(cnt_q);
                end
            end

            S_ACK: begin
                if (!abus_req) begin
                    state_d  = S_IDLE;
                    sel_d    = 1'b0;
                    serr_d   = 1'b0;
                    srdata_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge abus_clk) begin
        if (abus_rst) begin
            state_q  <= S_IDLE;
            dir_wr_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= 1'b0;
            serr_q   <= 1'b0;
            srdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_wr_q <= dir_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            serr_q   <= serr_d;
            srdata_q <= srdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Strobes exist only in the single S_ACCESS cycle, so one per transfer at most.
    always_comb begin
        abus_ack    = (state_q == S_ACK);
        abus_sel    = sel_q;
        abus_serr   = serr_q;
        abus_srdata = srdata_q;
        reg_addr    = addr_q;
        reg_wdata   = wdata_q;
        reg_we      = (state_q == S_ACCESS) &&  dir_wr_q;
        reg_re      = (state_q == S_ACCESS) && !dir_wr_q;
    end

endmodule
